sample_fifo: RTL and testbench
==============================

// Module: sample_fifo
// PURPOSE
//  Parametrised synchronous FIFO for microphone sample streams; next generation of the 9-bit/16-deep buffer.
//  Valid/ready handshake on both sides, simultaneous read+write, fill level, thresholds, flush.
//  Selectable full-policy: drop new sample or overwrite oldest. Saturating drop counter.
//  Sits between each sample deserialiser and the correlation/processing stage.
// PARAMETERS
//  DATA_WIDTH  9   sample width in bits
//  DEPTH       16  entries; power of 2, >= 2
//  OVERWRITE   0   0: full FIFO refuses writes; 1: write when full evicts oldest entry
//  AF_LEVEL    12  almost_full asserted when level >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    2   almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
//  DROP_W      8   drop counter width
//  (local) AW = $clog2(DEPTH)
// PORTS
//  clk           in   1           clock, all logic on rising edge
//  rst           in   1           reset, asynchronous, active-low
//  flush         in   1           synchronous clear of contents
//  in_data       in   DATA_WIDTH  write sample
//  in_valid      in   1           write request
//  in_ready      out  1           FIFO accepts write this cycle
//  out_data      out  DATA_WIDTH  oldest sample (first-word fall-through)
//  out_valid     out  1           out_data holds a sample
//  out_ready     in   1           consumer takes out_data this cycle
//  level         out  AW+1        entries currently stored, 0..DEPTH
//  almost_full   out  1           level >= AF_LEVEL
//  almost_empty  out  1           level <= AE_LEVEL
//  full          out  1           level == DEPTH
//  drop_cnt      out  DROP_W      samples lost to full condition, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): rd_ptr=wr_ptr=0, level=0, drop_cnt=0; out_valid=0, full=0, almost_full=0,
//    almost_empty=1, out_data=0 (storage not cleared; out_data forced 0 while level==0).
//    in_ready=1 during reset. Mid-operation reset discards all contents immediately.
//  - Storage: DEPTH x DATA_WIDTH register array; pointers AW bits, wrap DEPTH-1 -> 0 naturally.
//  - Write fire: wr = in_valid & in_ready. Read fire: rd = out_valid & out_ready.
//  - in_ready = (level != DEPTH) | OVERWRITE. out_valid = (level != 0).
//  - out_data = mem[rd_ptr] when level != 0, else 0. Write-to-out_valid latency 1 cycle
//    (no bypass: empty FIFO + write -> out_valid next cycle).
//  - Per cycle (priority order):
//    flush: pointers=0, level=0; wr/rd ignored, not counted as drops; drop_cnt kept.
//    wr & rd: mem[wr_ptr]<=in_data, both ptrs +1, level unchanged (legal at any level incl. full).
//    wr only, level<DEPTH: store, wr_ptr+1, level+1.
//    wr only, level==DEPTH (OVERWRITE=1): store, wr_ptr+1, rd_ptr+1, level stays DEPTH, drop_cnt+1.
//    rd only: rd_ptr+1, level-1.
//    in_valid & !in_ready (OVERWRITE=0, full, no same-cycle read): sample lost, drop_cnt+1.
//  - drop_cnt saturates at 2^DROP_W-1; cleared only by reset.
//  - full/almost_full/almost_empty derived from registered level; no combinational path
//    from in_valid/out_ready to any output.
//  - OVERWRITE=0: in_ready is 0 when full, even if out_ready=1 same cycle (no ready-through).
// TESTING
//  1 Reset then write 0x001..0x010 (DEPTH=16) -> level 16, full=1, in_ready=0, out_data=0x001.
//  2 Full, OVERWRITE=0, in_valid=1 x3 cycles, out_ready=0 -> drop_cnt=3, contents 0x001..0x010 intact.
//  3 Full, OVERWRITE=1, write 0x1AA -> level 16, drop_cnt=1, out_data=0x002, last read = 0x1AA.
//  4 Level 5, in_valid=out_ready=1 for 40 cycles with ramp data -> level stays 5, output order exact
//    across pointer wrap; almost_empty=0, almost_full=0.
//  5 Level 9, assert flush with in_valid=out_ready=1 -> next cycle level 0, out_valid=0, drop_cnt unchanged.
//  6 Drive rst low mid-stream (level 7) between edges -> level=0, out_valid=0 without clk edge;
//    DROP_W=2 overflow x5 -> drop_cnt=3 saturated.

Source files
------------

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with valid/ready on both sides, fill-level thresholds,
// flush, selectable full policy (refuse or overwrite oldest) and a saturating drop counter.
module sample_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 16,
  parameter int OVERWRITE  = 0,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter int DROP_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     full,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_LEVEL);
  localparam bit          OVR     = (OVERWRITE != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr;
  logic                  rd;
  logic                  evict;
  logic                  refuse;
  logic                  drop;

  // Status flags depend only on the registered level, never on this cycle's requests.
  assign full         = (level == DEPTH_L);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);
  assign out_valid    = (level != '0);
  assign in_ready     = !full || OVR;
  assign out_data     = out_valid ? mem[rd_ptr] : '0;

  assign wr     = in_valid & in_ready;
  assign rd     = out_valid & out_ready;
  assign evict  = wr & ~rd & full;
  assign refuse = in_valid & ~in_ready & ~rd;
  assign drop   = ~flush & (evict | refuse);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd || evict)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd && !full)
        level <= level + 1'b1;
      else if (rd && !wr)
        level <= level - 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; out_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (wr && !flush)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (drop && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 1'b1;
  end

endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: a refusing instance (DROP_W=8) and an overwriting instance
// (DROP_W=2) share one stimulus stream and are compared against queue models.
module tb_sample_fifo;
  localparam int DW    = 9;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  logic          a_in_ready, a_out_valid, a_af, a_ae, a_full;
  logic [DW-1:0] a_out_data;
  logic [AW:0]   a_level;
  logic [7:0]    a_drop;

  logic          b_in_ready, b_out_valid, b_af, b_ae, b_full;
  logic [DW-1:0] b_out_data;
  logic [AW:0]   b_level;
  logic [1:0]    b_drop;

  always #5 clk = ~clk;

  sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OVERWRITE(0), .AF_LEVEL(12),
                .AE_LEVEL(2), .DROP_W(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .level(a_level), .almost_full(a_af),
    .almost_empty(a_ae), .full(a_full), .drop_cnt(a_drop));

  sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OVERWRITE(1), .AF_LEVEL(12),
                .AE_LEVEL(2), .DROP_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .level(b_level), .almost_full(b_af),
    .almost_empty(b_ae), .full(b_full), .drop_cnt(b_drop));

  int qa[$];
  int qb[$];
  int drop_a = 0;
  int drop_b = 0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock of FIFO behaviour expressed as queue operations.
  task automatic model_step(inout int q[$], inout int drop, input bit ow, input int dmax);
    bit ir, ov, wr, rd;
    ir = (q.size() != DEPTH) || ow;
    ov = (q.size() != 0);
    if (flush) begin
      q.delete();
      return;
    end
    wr = in_valid && ir;
    rd = ov && out_ready;
    if (rd)
      void'(q.pop_front());
    if (wr) begin
      if (!rd && q.size() == DEPTH) begin
        void'(q.pop_front());
        if (drop < dmax) drop++;
      end
      q.push_back(int'(in_data));
    end
    if (in_valid && !ir && !rd && drop < dmax)
      drop++;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qa.delete();
      qb.delete();
      drop_a = 0;
      drop_b = 0;
    end else begin
      model_step(qa, drop_a, 1'b0, 255);
      model_step(qb, drop_b, 1'b1, 3);
    end
  end

  task automatic cmp(input string t, input int q[$], input int drop, input bit ow,
                     input int ir, input int ov, input int od, input int lv,
                     input int af, input int ae, input int fu, input int dc);
    int n;
    n = q.size();
    check({t, ".level"},        lv, n);
    check({t, ".in_ready"},     ir, int'((n != DEPTH) || ow));
    check({t, ".out_valid"},    ov, int'(n != 0));
    check({t, ".out_data"},     od, (n != 0) ? q[0] : 0);
    check({t, ".full"},         fu, int'(n == DEPTH));
    check({t, ".almost_full"},  af, int'(n >= 12));
    check({t, ".almost_empty"}, ae, int'(n <= 2));
    check({t, ".drop_cnt"},     dc, drop);
  endtask

  always @(negedge clk) begin
    cmp("A", qa, drop_a, 1'b0, a_in_ready, a_out_valid, a_out_data, a_level,
        a_af, a_ae, a_full, a_drop);
    cmp("B", qb, drop_b, 1'b1, b_in_ready, b_out_valid, b_out_data, b_level,
        b_af, b_ae, b_full, b_drop);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    int pv;
    int pr;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) cyc();
    check("rst.level", a_level, 0);
    check("rst.almost_empty", a_ae, 1);
    check("rst.in_ready", a_in_ready, 1);
    check("rst.out_data", a_out_data, 0);
    rst = 1'b1;
    cyc();

    // Fill to exactly DEPTH.
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      cyc();
    end
    check("fill.level", a_level, 16);
    check("fill.full", a_full, 1);
    check("fill.in_ready", a_in_ready, 0);
    check("fill.out_data", a_out_data, 1);
    check("fill.b_in_ready", b_in_ready, 1);

    // Writes into a full FIFO: A refuses, B evicts oldest.
    in_data = 9'h1AA; cyc();
    check("ovr.b_level", b_level, 16);
    check("ovr.b_drop", b_drop, 1);
    check("ovr.b_out_data", b_out_data, 2);
    check("ovr.a_drop", a_drop, 1);
    in_data = 9'h1AB; cyc();
    in_data = 9'h1AC; cyc();
    check("drop3.a_drop", a_drop, 3);
    check("drop3.a_out_data", a_out_data, 1);
    check("drop3.b_out_data", b_out_data, 4);
    in_data = 9'h1AD; cyc();
    in_data = 9'h1AE; cyc();
    check("sat.a_drop", a_drop, 5);
    check("sat.b_drop", b_drop, 3);
    in_valid = 1'b0;

    // Drain: A holds 1..16 intact, B holds 6..16 then the five overwrites.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain.a_out_data", a_out_data, i + 1);
      check("drain.b_out_data", b_out_data, (i < 11) ? i + 6 : 'h1AA + (i - 11));
      cyc();
    end
    out_ready = 1'b0;
    check("drain.a_level", a_level, 0);
    check("drain.a_out_valid", a_out_valid, 0);

    // Level 5 with continuous read+write across pointer wrap.
    d = 'h20;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(d); d++;
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check("stream.a_out_data", a_out_data, 'h20 + k);
      in_data = DW'(d); d++;
      cyc();
    end
    check("stream.a_level", a_level, 5);
    check("stream.b_level", b_level, 5);
    check("stream.almost_empty", a_ae, 0);
    check("stream.almost_full", a_af, 0);

    // Level 9, flush wins over simultaneous read and write.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = DW'(d); d++;
      cyc();
    end
    check("pre_flush.level", a_level, 9);
    flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush.level", a_level, 0);
    check("flush.out_valid", a_out_valid, 0);
    check("flush.a_drop", a_drop, 5);
    check("flush.b_drop", b_drop, 3);

    // Asynchronous reset between edges at level 7.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = DW'(d); d++;
      cyc();
    end
    in_valid = 1'b0;
    check("pre_rst.level", a_level, 7);
    #2 rst = 1'b0;
    #1;
    check("async_rst.a_level", a_level, 0);
    check("async_rst.a_out_valid", a_out_valid, 0);
    check("async_rst.b_level", b_level, 0);
    check("async_rst.a_drop", a_drop, 0);
    #3 rst = 1'b1;
    cyc();

    // Randomised traffic with varying pressure, compared every cycle.
    for (int blk = 0; blk < 12; blk++) begin
      pv = $urandom_range(95, 20);
      pr = $urandom_range(95, 20);
      for (int c = 0; c < 200; c++) begin
        in_valid  = ($urandom_range(99, 0) < pv);
        out_ready = ($urandom_range(99, 0) < pr);
        in_data   = DW'($urandom);
        flush     = ($urandom_range(99, 0) == 0);
        cyc();
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
